// File: rtl/reg_file_pkg.sv
// Shared definitions for the multiport register file: default widths,
// the zero-register index and the byte-merge helper used by write and bypass.
package reg_file_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int ZERO_IDX       = 0;

  // Widest register the merge helper handles; narrower callers zero-extend
  // their operands and truncate the result.
  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

  // Replace each byte of old_val whose enable bit is set with the matching
  // byte of new_val; bytes with a clear enable keep their old contents.
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_val,
    input logic [MAX_DATA_WIDTH-1:0] new_val,
    input logic [MAX_BE_WIDTH-1:0]   be
  );
    logic [MAX_DATA_WIDTH-1:0] res;
    res = old_val;
    for (int i = 0; i < MAX_BE_WIDTH; i++) begin
      if (be[i]) begin
        res[i*8 +: 8] = new_val[i*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register pending scoreboard: one bit per register marks an outstanding
// producer. Issue sets a bit, a writeback with any byte enabled clears it,
// and each read port reports whether its register is still in flight.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr_en,
  input  logic [ADDR_WIDTH-1:0]          clr_reg,
  input  logic                           set_en,
  input  logic [ADDR_WIDTH-1:0]          set_reg,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_reg,
  input  logic [NUM_READ-1:0]            bypass_full,
  output logic [NUM_READ-1:0]            read_busy,
  output logic                           any_pending
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0] pending;
  logic             set_ok;

  // The zero register never has a producer, so marking it is dropped.
  always_comb begin
    set_ok = set_en && !(ZERO_REG && (set_reg == ADDR_WIDTH'(ZERO_IDX)));
  end

  // Clear is applied first and set second, so a new producer issuing to the
  // register that is being written back this cycle leaves the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (clr_en) begin
        pending[clr_reg] <= 1'b0;
      end
      if (set_ok) begin
        pending[set_reg] <= 1'b1;
      end
    end
  end

  // Derived only from the pending flops, never from this cycle's inputs.
  always_comb begin
    any_pending = |pending;
  end

  // A read is busy while its register is pending, unless a full-width write
  // to that register is being forwarded to it this very cycle.
  always_comb begin
    read_busy = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      read_busy[k] = pending[read_reg[k*ADDR_WIDTH +: ADDR_WIDTH]] && !bypass_full[k];
    end
  end

endmodule

// File: rtl/reg_file_multiport.sv
// Parametrised decode-stage register file: one byte-enabled write port,
// NUM_READ combinational read ports with optional write-to-read forwarding,
// an optional hardwired zero register and a pending scoreboard.
module reg_file_multiport
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter bit BYPASS     = 1'b1,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           RegWrite,
  input  logic [ADDR_WIDTH-1:0]          write_reg,
  input  logic [DATA_WIDTH-1:0]          write_data,
  input  logic [DATA_WIDTH/8-1:0]        write_be,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_reg,
  output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
  output logic [NUM_READ-1:0]            read_busy,
  input  logic                           pend_set,
  input  logic [ADDR_WIDTH-1:0]          pend_reg,
  output logic                           any_pending
);

  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // Reject configurations the byte lanes or port muxes cannot represent.
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
    $error("reg_file_multiport: DATA_WIDTH must be a multiple of 8 between 8 and %0d", MAX_DATA_WIDTH);
  end
  if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_ports
    $error("reg_file_multiport: NUM_READ must be 1..4");
  end

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DATA_WIDTH-1:0] write_merged;
  logic                  write_to_zero;
  logic                  write_commit;
  logic                  clr_en;
  logic [NUM_READ-1:0]   bypass_full;

  // The value the target register will hold after this edge; shared by the
  // storage update and by every forwarding read port.
  always_comb begin
    write_merged  = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(regs[write_reg]),
                                           MAX_DATA_WIDTH'(write_data),
                                           MAX_BE_WIDTH'(write_be)));
    write_to_zero = ZERO_REG && (write_reg == ADDR_WIDTH'(ZERO_IDX));
    write_commit  = RegWrite && !write_to_zero;
    clr_en        = RegWrite && (write_be != '0);
  end

  // Storage update; an all-zero byte enable merges to the old value, so it
  // naturally leaves the register untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_commit) begin
      regs[write_reg] <= write_merged;
    end
  end

  // Per-port read mux: zero register, forwarded write, or stored value.
  always_comb begin
    read_data   = '0;
    bypass_full = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      logic [ADDR_WIDTH-1:0] idx;
      logic                  is_zero;
      logic                  hit;
      idx     = read_reg[k*ADDR_WIDTH +: ADDR_WIDTH];
      is_zero = ZERO_REG && (idx == ADDR_WIDTH'(ZERO_IDX));
      hit     = BYPASS && RegWrite && (idx == write_reg) && !is_zero;
      if (is_zero) begin
        read_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else if (hit) begin
        read_data[k*DATA_WIDTH +: DATA_WIDTH] = write_merged;
      end else begin
        read_data[k*DATA_WIDTH +: DATA_WIDTH] = regs[idx];
      end
      bypass_full[k] = hit && (write_be == {BE_WIDTH{1'b1}});
    end
  end

  reg_file_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .clr_en      (clr_en),
    .clr_reg     (write_reg),
    .set_en      (pend_set),
    .set_reg     (pend_reg),
    .read_reg    (read_reg),
    .bypass_full (bypass_full),
    .read_busy   (read_busy),
    .any_pending (any_pending)
  );

endmodule

// File: tb/tb_reg_file_multiport.sv
// Self-checking bench for reg_file_multiport. Two instances share all inputs:
// dut_a uses the defaults (bypass on, zero register on) and dut_b has both
// features off. A reference model predicts each cycle's outputs, which are
// queued when stimulus is applied and popped when the outputs are sampled.
module tb_reg_file_multiport;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [3:0]  write_be;
  logic [9:0]  read_reg;
  logic        pend_set;
  logic [4:0]  pend_reg;

  logic [63:0] read_data_a, read_data_b;
  logic [1:0]  read_busy_a, read_busy_b;
  logic        any_pending_a, any_pending_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          r;
    bit          we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [4:0]  r0;
    logic [4:0]  r1;
    bit          ps;
    logic [4:0]  pr;
  } step_t;

  typedef struct {
    logic [63:0] da;
    logic [2:0]  sa;
    logic [63:0] db;
    logic [2:0]  sb;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] ma [32];
  logic [31:0] mb [32];
  logic [31:0] pa;
  logic [31:0] pb;

  reg_file_multiport #(
    .DATA_WIDTH (32), .ADDR_WIDTH (5), .NUM_READ (2), .BYPASS (1'b1), .ZERO_REG (1'b1)
  ) dut_a (
    .clk (clk), .rst (rst), .RegWrite (RegWrite), .write_reg (write_reg),
    .write_data (write_data), .write_be (write_be), .read_reg (read_reg),
    .read_data (read_data_a), .read_busy (read_busy_a), .pend_set (pend_set),
    .pend_reg (pend_reg), .any_pending (any_pending_a)
  );

  reg_file_multiport #(
    .DATA_WIDTH (32), .ADDR_WIDTH (5), .NUM_READ (2), .BYPASS (1'b0), .ZERO_REG (1'b0)
  ) dut_b (
    .clk (clk), .rst (rst), .RegWrite (RegWrite), .write_reg (write_reg),
    .write_data (write_data), .write_be (write_be), .read_reg (read_reg),
    .read_data (read_data_b), .read_busy (read_busy_b), .pend_set (pend_set),
    .pend_reg (pend_reg), .any_pending (any_pending_b)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(bit r, bit we, logic [4:0] wr, logic [31:0] wd, logic [3:0] be,
                               logic [4:0] r0, logic [4:0] r1, bit ps, logic [4:0] pr);
    step_t s;
    s.r = r; s.we = we; s.wr = wr; s.wd = wd; s.be = be;
    s.r0 = r0; s.r1 = r1; s.ps = ps; s.pr = pr;
    return s;
  endfunction

  function automatic logic [31:0] model_merge(logic [31:0] old_v, logic [31:0] new_v, logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  function automatic logic [31:0] exp_read_a(logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (RegWrite && idx == write_reg) return model_merge(ma[idx], write_data, write_be);
    return ma[idx];
  endfunction

  function automatic logic exp_busy_a(logic [4:0] idx);
    if (RegWrite && idx == write_reg && idx != 5'd0 && write_be == 4'hF) return 1'b0;
    return pa[idx];
  endfunction

  task automatic drive(step_t s);
    rst        = s.r;
    RegWrite   = s.we;
    write_reg  = s.wr;
    write_data = s.wd;
    write_be   = s.be;
    read_reg   = {s.r1, s.r0};
    pend_set   = s.ps;
    pend_reg   = s.pr;
  endtask

  task automatic push_expected();
    exp_t e;
    logic [4:0] r0, r1;
    r0 = read_reg[4:0];
    r1 = read_reg[9:5];
    e.da = {exp_read_a(r1), exp_read_a(r0)};
    e.sa = {exp_busy_a(r1), exp_busy_a(r0), |pa};
    e.db = {mb[r1], mb[r0]};
    e.sb = {pb[r1], pb[r0], |pb};
    exp_q.push_back(e);
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        ma[i] = 32'h0;
        mb[i] = 32'h0;
      end
      pa = 32'h0;
      pb = 32'h0;
    end else begin
      if (RegWrite) begin
        if (write_reg != 5'd0) ma[write_reg] = model_merge(ma[write_reg], write_data, write_be);
        mb[write_reg] = model_merge(mb[write_reg], write_data, write_be);
        if (write_be != 4'h0) begin
          pa[write_reg] = 1'b0;
          pb[write_reg] = 1'b0;
        end
      end
      if (pend_set) begin
        if (pend_reg != 5'd0) pa[pend_reg] = 1'b1;
        pb[pend_reg] = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(1, 1, 5'd3, 32'hDEADBEEF, 4'hF, 5'd3, 5'd4, 1, 5'd4));
    st.push_back(mk(0, 0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd4, 0, 5'd0));
    st.push_back(mk(0, 0, 5'd0, 32'h0, 4'h0, 5'd1, 5'd31, 0, 5'd0));
    foreach (st[i]) begin
      @(negedge clk);
      drive(st[i]);
      push_expected();
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if ({read_data_a, read_busy_a, any_pending_a} !== {e.da, e.sa}) begin
        n_errors++;
        $display("[TB] FAIL reset step %0d dut_a: got data=%h flags=%b expected data=%h flags=%b",
                 i, read_data_a, {read_busy_a, any_pending_a}, e.da, e.sa);
      end
      n_checks++;
      if ({read_data_b, read_busy_b, any_pending_b} !== {e.db, e.sb}) begin
        n_errors++;
        $display("[TB] FAIL reset step %0d dut_b: got data=%h flags=%b expected data=%h flags=%b",
                 i, read_data_b, {read_busy_b, any_pending_b}, e.db, e.sb);
      end
      @(posedge clk);
      model_edge();
    end
  endtask

  task automatic test_zero_reg();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 1, 5'd0, 32'hAAAAAAAA, 4'hF, 5'd0, 5'd0, 1, 5'd0));
    st.push_back(mk(0, 0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd1, 0, 5'd0));
    st.push_back(mk(0, 1, 5'd0, 32'h0, 4'hF, 5'd0, 5'd0, 0, 5'd0));
    foreach (st[i]) begin
      @(negedge clk);
      drive(st[i]);
      push_expected();
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if ({read_data_a, read_busy_a, any_pending_a} !== {e.da, e.sa}) begin
        n_errors++;
        $display("[TB] FAIL zero_reg step %0d dut_a: got data=%h flags=%b expected data=%h flags=%b",
                 i, read_data_a, {read_busy_a, any_pending_a}, e.da, e.sa);
      end
      n_checks++;
      if ({read_data_b, read_busy_b, any_pending_b} !== {e.db, e.sb}) begin
        n_errors++;
        $display("[TB] FAIL zero_reg step %0d dut_b: got data=%h flags=%b expected data=%h flags=%b",
                 i, read_data_b, {read_busy_b, any_pending_b}, e.db, e.sb);
      end
      @(posedge clk);
      model_edge();
    end
  endtask

  task automatic test_bypass();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 1, 5'd1, 32'hAAAAAAAA, 4'hF, 5'd1, 5'd2, 0, 5'd0));
    st.push_back(mk(0, 0, 5'd0, 32'h0, 4'h0, 5'd1, 5'd2, 0, 5'd0));
    st.push_back(mk(0, 1, 5'd31, 32'h5A5A1234, 4'hF, 5'd31, 5'd31, 0, 5'd0));
    st.push_back(mk(0, 0, 5'd0, 32'h0, 4'h0, 5'd31, 5'd1, 0, 5'd0));
    foreach (st[i]) begin
      @(negedge clk);
      drive(st[i]);
      push_expected();
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if ({read_data_a, read_busy_a, any_pending_a} !== {e.da, e.sa}) begin
        n_errors++;
        $display("[TB] FAIL bypass step %0d dut_a: got data=%h flags=%b expected data=%h flags=%b",
                 i, read_data_a, {read_busy_a, any_pending_a}, e.da, e.sa);
      end
      n_checks++;
      if ({read_data_b, read_busy_b, any_pending_b} !== {e.db, e.sb}) begin
        n_errors++;
        $display("[TB] FAIL bypass step %0d dut_b: got data=%h flags=%b expected data=%h flags=%b",
                 i, read_data_b, {read_busy_b, any_pending_b}, e.db, e.sb);
      end
      @(posedge clk);
      model_edge();
    end
  endtask

  task automatic test_byte_enable();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 1, 5'd5, 32'h11223344, 4'hF, 5'd5, 5'd6, 0, 5'd0));
    st.push_back(mk(0, 1, 5'd5, 32'hFFFFFFFF, 4'b0101, 5'd5, 5'd5, 0, 5'd0));
    st.push_back(mk(0, 0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd0, 0, 5'd0));
    st.push_back(mk(0, 1, 5'd5, 32'h00000000, 4'h0, 5'd5, 5'd5, 0, 5'd0));
    st.push_back(mk(0, 1, 5'd5, 32'hCAFE0000, 4'b1010, 5'd6, 5'd5, 0, 5'd0));
    st.push_back(mk(0, 0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd6, 0, 5'd0));
    foreach (st[i]) begin
      @(negedge clk);
      drive(st[i]);
      push_expected();
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if ({read_data_a, read_busy_a, any_pending_a} !== {e.da, e.sa}) begin
        n_errors++;
        $display("[TB] FAIL byte_enable step %0d dut_a: got data=%h flags=%b expected data=%h flags=%b",
                 i, read_data_a, {read_busy_a, any_pending_a}, e.da, e.sa);
      end
      n_checks++;
      if ({read_data_b, read_busy_b, any_pending_b} !== {e.db, e.sb}) begin
        n_errors++;
        $display("[TB] FAIL byte_enable step %0d dut_b: got data=%h flags=%b expected data=%h flags=%b",
                 i, read_data_b, {read_busy_b, any_pending_b}, e.db, e.sb);
      end
      @(posedge clk);
      model_edge();
    end
  endtask

  task automatic test_scoreboard();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd1, 1, 5'd7));
    st.push_back(mk(0, 0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd7, 0, 5'd0));
    st.push_back(mk(0, 1, 5'd7, 32'h77777777, 4'hF, 5'd7, 5'd7, 0, 5'd0));
    st.push_back(mk(0, 0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd8, 1, 5'd8));
    st.push_back(mk(0, 1, 5'd8, 32'h0000BEEF, 4'b0011, 5'd8, 5'd7, 1, 5'd10));
    st.push_back(mk(0, 1, 5'd10, 32'h12345678, 4'h0, 5'd8, 5'd10, 0, 5'd0));
    st.push_back(mk(0, 1, 5'd10, 32'h12345678, 4'hF, 5'd10, 5'd8, 0, 5'd0));
    st.push_back(mk(0, 0, 5'd0, 32'h0, 4'h0, 5'd10, 5'd31, 0, 5'd0));
    foreach (st[i]) begin
      @(negedge clk);
      drive(st[i]);
      push_expected();
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if ({read_data_a, read_busy_a, any_pending_a} !== {e.da, e.sa}) begin
        n_errors++;
        $display("[TB] FAIL scoreboard step %0d dut_a: got data=%h flags=%b expected data=%h flags=%b",
                 i, read_data_a, {read_busy_a, any_pending_a}, e.da, e.sa);
      end
      n_checks++;
      if ({read_data_b, read_busy_b, any_pending_b} !== {e.db, e.sb}) begin
        n_errors++;
        $display("[TB] FAIL scoreboard step %0d dut_b: got data=%h flags=%b expected data=%h flags=%b",
                 i, read_data_b, {read_busy_b, any_pending_b}, e.db, e.sb);
      end
      @(posedge clk);
      model_edge();
    end
  endtask

  task automatic test_set_clear_reset();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 1, 5'd9, 32'h99999999, 4'hF, 5'd9, 5'd11, 1, 5'd9));
    st.push_back(mk(0, 0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd11, 0, 5'd0));
    st.push_back(mk(0, 1, 5'd9, 32'h09090909, 4'hF, 5'd11, 5'd9, 1, 5'd11));
    st.push_back(mk(0, 0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd11, 1, 5'd31));
    st.push_back(mk(1, 1, 5'd11, 32'hFFFFFFFF, 4'hF, 5'd9, 5'd31, 1, 5'd12));
    st.push_back(mk(0, 0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd11, 0, 5'd0));
    st.push_back(mk(0, 0, 5'd0, 32'h0, 4'h0, 5'd12, 5'd31, 0, 5'd0));
    foreach (st[i]) begin
      @(negedge clk);
      drive(st[i]);
      push_expected();
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if ({read_data_a, read_busy_a, any_pending_a} !== {e.da, e.sa}) begin
        n_errors++;
        $display("[TB] FAIL set_clear_reset step %0d dut_a: got data=%h flags=%b expected data=%h flags=%b",
                 i, read_data_a, {read_busy_a, any_pending_a}, e.da, e.sa);
      end
      n_checks++;
      if ({read_data_b, read_busy_b, any_pending_b} !== {e.db, e.sb}) begin
        n_errors++;
        $display("[TB] FAIL set_clear_reset step %0d dut_b: got data=%h flags=%b expected data=%h flags=%b",
                 i, read_data_b, {read_busy_b, any_pending_b}, e.db, e.sb);
      end
      @(posedge clk);
      model_edge();
    end
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    exp_t  e;
    for (int n = 0; n < 60; n++) begin
      logic [4:0] wr, r0, r1, pr;
      wr = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      r0 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 7));
      pr = 5'($urandom_range(0, 7));
      st.push_back(mk(0, 1'($urandom_range(0, 1)), wr, $urandom, 4'($urandom_range(0, 15)),
                      r0, r1, ($urandom_range(0, 2) == 0), pr));
    end
    foreach (st[i]) begin
      @(negedge clk);
      drive(st[i]);
      push_expected();
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if ({read_data_a, read_busy_a, any_pending_a} !== {e.da, e.sa}) begin
        n_errors++;
        $display("[TB] FAIL back_to_back step %0d dut_a: got data=%h flags=%b expected data=%h flags=%b",
                 i, read_data_a, {read_busy_a, any_pending_a}, e.da, e.sa);
      end
      n_checks++;
      if ({read_data_b, read_busy_b, any_pending_b} !== {e.db, e.sb}) begin
        n_errors++;
        $display("[TB] FAIL back_to_back step %0d dut_b: got data=%h flags=%b expected data=%h flags=%b",
                 i, read_data_b, {read_busy_b, any_pending_b}, e.db, e.sb);
      end
      @(posedge clk);
      model_edge();
    end
  endtask

  initial begin
    drive(mk(1, 0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 0, 5'd0));
    @(posedge clk);
    model_edge();
    $display("[TB] initial reset applied");
    test_reset();
    test_zero_reg();
    test_bypass();
    test_byte_enable();
    test_scoreboard();
    test_set_clear_reset();
    test_back_to_back();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
